fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter.
// Default sizing for producers, data and FIFO depth, plus derived widths.
package fifo_arb_pkg;
  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 4;                  // width of the FIFO occupancy input
  localparam int PTR_W      = $clog2(NUM_REQ);    // round-robin pointer width
  localparam int STAT_W     = 16;                 // per-producer transfer counter width
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
// Searches from (i_last_ptr+1) mod NUM_REQ upward, wrapping, and returns the
// first requesting index as a one-hot pick plus its binary index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_last_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [PTR_W-1:0]   o_idx
);
  import fifo_arb_pkg::*;

  logic             w_found;
  logic [PTR_W-1:0] w_cand;

  // Walk the NUM_REQ positions after the last winner; the first requester wins.
  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (int'(i_last_ptr) + k >= NUM_REQ) begin
        w_cand = PTR_W'(int'(i_last_ptr) + k - NUM_REQ);
      end else begin
        w_cand = PTR_W'(int'(i_last_ptr) + k);
      end
      if (!w_found && i_req[w_cand]) begin
        w_found        = 1'b1;
        o_pick[w_cand] = 1'b1;
        o_idx          = w_cand;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grant is combinational; the FIFO write strobe and data are registered one
// cycle after the transfer. A write already in flight reserves one FIFO slot,
// so the FIFO can never be overrun.
// Optional feature: define FIFO_ARB_STATS_EN to add gnt_cnt, a set of
// saturating 16-bit per-producer transfer counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = fifo_arb_pkg::NUM_REQ,
  parameter int DATA_W     = fifo_arb_pkg::DATA_W,
  parameter int FIFO_DEPTH = fifo_arb_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       arb_en,
  input  logic                       buf_full,
  input  logic [fifo_arb_pkg::CNT_W-1:0] fifo_counter,
  output logic                       wr_en,
  output logic [DATA_W-1:0]          buf_in,
  output logic                       busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*fifo_arb_pkg::STAT_W-1:0] gnt_cnt
`endif
);
  import fifo_arb_pkg::*;

  localparam int LP_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [LP_PTR_W-1:0] r_last_ptr;
  logic                r_wr_en;
  logic [DATA_W-1:0]   r_buf_in;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_pick;
  logic [LP_PTR_W-1:0] w_idx;
  logic [CNT_W:0]      w_occ;
  logic                w_space;
  logic                w_xfer;
  logic [DATA_W-1:0]   w_slot [NUM_REQ];

  // Unpack the producer data bus into per-producer slots.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign w_slot[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (LP_PTR_W)
  ) u_rr_pick (
    .i_req      (req),
    .i_last_ptr (r_last_ptr),
    .o_pick     (w_pick),
    .o_idx      (w_idx)
  );

  // Occupancy including the write already registered but not yet seen by the FIFO.
  assign w_occ   = {1'b0, fifo_counter} + {{CNT_W{1'b0}}, r_wr_en};
  assign w_space = arb_en & ~buf_full & (w_occ < (CNT_W+1)'(FIFO_DEPTH));
  assign gnt     = (w_space && !rst) ? w_pick : '0;
  assign w_xfer  = |gnt;   // gnt only ever sets bits that are also requesting

  // Register the FIFO write, pointer update on transfer, and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_buf_in   <= '0;
      r_busy     <= 1'b0;
      r_last_ptr <= LP_PTR_W'(NUM_REQ - 1);
    end else begin
      r_wr_en <= w_xfer;
      r_busy  <= |req;
      if (w_xfer) begin
        r_buf_in   <= w_slot[w_idx];
        r_last_ptr <= w_idx;
      end
    end
  end

  assign wr_en  = r_wr_en;
  assign buf_in = r_buf_in;
  assign busy   = r_busy;

`ifdef FIFO_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      logic [STAT_W-1:0] r_cnt;
      // Count this producer's transfers, sticking at all-ones.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (gnt[gi] && (r_cnt != {STAT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign gnt_cnt[gi*STAT_W +: STAT_W] = r_cnt;
    end
  endgenerate
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        arb_en;
  logic        buf_full;
  logic [3:0]  fifo_counter;
  logic        wr_en;
  logic [7:0]  buf_in;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] gnt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .arb_en       (arb_en),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter),
    .wr_en        (wr_en),
    .buf_in       (buf_in),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .gnt_cnt      (gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = 4'b0000; arb_en = 1'b1; buf_full = 1'b0; fifo_counter = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 4'b1111; arb_en = 1'b1; buf_full = 1'b0; fifo_counter = 4'd0;
    req_data = 32'h44332211;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (buf_in !== 8'h00) begin errors++; $display("FAIL reset_buf_in: got %h expected 00", buf_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0; req = 4'b0000;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0001; req_data = 32'h000000A5;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    tick();
    $display("tx single: wr_en=%b buf_in=%h", wr_en, buf_in);
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b expected 1", wr_en); end
    checks++; if (buf_in !== 8'hA5) begin errors++; $display("FAIL single_buf_in: got %h expected a5", buf_in); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    req = 4'b0000;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en: got %b expected 0", wr_en); end
    checks++; if (buf_in !== 8'hA5) begin errors++; $display("FAIL idle_buf_hold: got %h expected a5", buf_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin;
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req = 4'b1111; req_data = 32'h44332211;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << exp_idx[n];
      exp_d = 8'h11 * 8'(exp_idx[n] + 1);
      #1;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", n, gnt, exp_g); end
      tick();
      $display("tx rr %0d: gnt_idx=%0d wr_en=%b buf_in=%h", n, exp_idx[n], wr_en, buf_in);
      checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en[%0d]: got %b expected 1", n, wr_en); end
      checks++; if (buf_in !== exp_d) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", n, buf_in, exp_d); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_fill;
    int cnt = 0;
    int pulses = 0;
    logic wr_model = 1'b0;
    logic exp_g;
    do_reset();
    req = 4'b0001; req_data = 32'h000000C3;
    for (int n = 0; n < 16; n++) begin
      fifo_counter = 4'(cnt);
      buf_full = (cnt == 8);
      exp_g = ((cnt + int'(wr_model)) < 8);
      #1;
      checks++; if (gnt !== {3'b000, exp_g}) begin errors++; $display("FAIL fill_gnt[%0d]: got %b expected %b (cnt=%0d)", n, gnt, {3'b000, exp_g}, cnt); end
      checks++; if (wr_en !== wr_model) begin errors++; $display("FAIL fill_wr_en[%0d]: got %b expected %b", n, wr_en, wr_model); end
      tick();
      cnt = cnt + int'(wr_model);
      wr_model = exp_g;
      if (wr_en === 1'b1) begin
        pulses++;
        $display("tx fill %0d: write %0d buf_in=%h", n, pulses, buf_in);
      end
    end
    checks++; if (pulses != 8) begin errors++; $display("FAIL fill_pulses: got %0d expected 8", pulses); end
    req = 4'b0000; buf_full = 1'b0; fifo_counter = 4'd0;
    tick();
  endtask

  task automatic test_counter7;
    do_reset();
    req = 4'b1000; req_data = 32'h44332211; fifo_counter = 4'd7;
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL c7_free_gnt: got %b expected 1000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL c7_inflight_gnt: got %b expected 0000", gnt); end
    checks++; if (buf_in !== 8'h44) begin errors++; $display("FAIL c7_data: got %h expected 44", buf_in); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL c7_wr_en: got %b expected 0", wr_en); end
    req = 4'b0000; fifo_counter = 4'd0;
  endtask

  task automatic test_buf_full;
    do_reset();
    req = 4'b0110; req_data = 32'h44332211; buf_full = 1'b1; fifo_counter = 4'd3;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL full_gnt: got %b expected 0000", gnt); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_en: got %b expected 0", wr_en); end
    buf_full = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL unfull_gnt: got %b expected 0010", gnt); end
    tick();
    checks++; if (buf_in !== 8'h22) begin errors++; $display("FAIL unfull_data: got %h expected 22", buf_in); end
    req = 4'b0000; fifo_counter = 4'd0;
  endtask

  task automatic test_arb_en;
    do_reset();
    req = 4'b0001; req_data = 32'h44332211;
    tick();
    arb_en = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL dis_gnt: got %b expected 0000", gnt); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL dis_inflight: got %b expected 1", wr_en); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL dis_wr_en: got %b expected 0", wr_en); end
    arb_en = 1'b1; req = 4'b0000;
  endtask

  task automatic test_rst_mid;
    do_reset();
    req = 4'b0100; req_data = 32'h44332211;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b expected 0100", gnt); end
    tick();
    rst = 1'b1; req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en: got %b expected 0", wr_en); end
    checks++; if (buf_in !== 8'h00) begin errors++; $display("FAIL mid_buf_in: got %h expected 00", buf_in); end
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_after_gnt: got %b expected 0001", gnt); end
    tick();
    checks++; if (buf_in !== 8'h11) begin errors++; $display("FAIL mid_after_data: got %h expected 11", buf_in); end
    req = 4'b0000;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats;
    do_reset();
    checks++; if (gnt_cnt !== 64'h0) begin errors++; $display("FAIL stat_reset: got %h expected 0", gnt_cnt); end
    req = 4'b0100; req_data = 32'h44332211;
    tick(); tick(); tick();
    req = 4'b0000;
    tick();
    checks++; if (gnt_cnt !== 64'h0000_0003_0000_0000) begin errors++; $display("FAIL stat_three: got %h expected 0000000300000000", gnt_cnt); end
    do_reset();
    req = 4'b0001;
    repeat (65537) tick();
    req = 4'b0000;
    tick();
    checks++; if (gnt_cnt !== 64'h0000_0000_0000_FFFF) begin errors++; $display("FAIL stat_sat: got %h expected 000000000000ffff", gnt_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; req_data = '0; arb_en = 1'b1; buf_full = 1'b0; fifo_counter = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fill();
    test_counter7();
    test_buf_full();
    test_arb_en();
    test_rst_mid();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
